// File: rtl/prim_reg_bus_pkg.sv
// Shared types and constants for the register-bus adapter and its address decoder.
package prim_reg_bus_pkg;

  localparam int unsigned WordBytes = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  function automatic int unsigned idx_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/prim_reg_bus_decode.sv
// Combinational address decode: one-hot register select plus access-error flag.
module prim_reg_bus_decode
  import prim_reg_bus_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned NumRegs = 8
) (
  input  logic [AW-1:0]      addr_i,
  input  logic               we_i,
  input  logic [DW/8-1:0]    be_i,
  output logic [NumRegs-1:0] sel_o,
  output logic               err_o
);

  localparam int unsigned OffW = $clog2(WordBytes);

  logic [AW-OffW-1:0] idx;
  logic               range_err;
  logic               align_err;
  logic               be_err;

  assign idx = addr_i[AW-1:OffW];

  // One extra bit so NumRegs == 2^(AW-2) does not wrap to zero.
  assign range_err = ({1'b0, idx} >= (AW-OffW+1)'(NumRegs));
  assign align_err = |addr_i[OffW-1:0];
  assign be_err    = we_i && (be_i != '1);
  assign err_o     = range_err || align_err || be_err;

  always_comb begin
    sel_o = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      sel_o[i] = !err_o && (idx == (AW-OffW)'(i));
    end
  end

endmodule

// File: rtl/prim_reg_bus_adapter.sv
// Single-outstanding req/gnt bus to per-register write/read strobes with registered response.
module prim_reg_bus_adapter
  import prim_reg_bus_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned NumRegs = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DW-1:0]         wdata_i,
  input  logic [DW/8-1:0]       be_i,
  output logic                  gnt_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DW-1:0]         rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic [NumRegs-1:0]    reg_we_o,
  output logic [NumRegs-1:0]    reg_re_o,
  output logic [DW-1:0]         reg_wd_o,
  input  logic [NumRegs*DW-1:0] reg_q_i
);

  logic [NumRegs-1:0] dec_sel;
  logic               dec_err;

  prim_reg_bus_decode #(
    .AW      (AW),
    .DW      (DW),
    .NumRegs (NumRegs)
  ) u_decode (
    .addr_i (addr_i),
    .we_i   (we_i),
    .be_i   (be_i),
    .sel_o  (dec_sel),
    .err_o  (dec_err)
  );

  state_e             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               err_q, err_d;
  logic [NumRegs-1:0] reg_we_q, reg_we_d;
  logic [NumRegs-1:0] reg_re_q, reg_re_d;
  logic [DW-1:0]      reg_wd_q, reg_wd_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_error_q, rsp_error_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [DW-1:0]      access_rdata;

  // The read strobe is already one-hot on the target register, so it doubles as the mux select.
  always_comb begin
    access_rdata = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (reg_re_q[i]) begin
        access_rdata = access_rdata | reg_q_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    err_d       = err_q;
    reg_we_d    = '0;
    reg_re_d    = '0;
    reg_wd_d    = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        gnt_d = 1'b1;
        if (gnt_q && req_i) begin
          state_d = StAccess;
          gnt_d   = 1'b0;
          err_d   = dec_err;
          if (we_i) begin
            reg_we_d = dec_sel;
            reg_wd_d = dec_err ? '0 : wdata_i;
          end else begin
            reg_re_d = dec_sel;
          end
        end
      end
      StAccess: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_error_d = err_q;
        rsp_rdata_d = access_rdata;
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d     = StIdle;
          gnt_d       = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      err_q       <= 1'b0;
      reg_we_q    <= '0;
      reg_re_q    <= '0;
      reg_wd_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      reg_wd_q    <= reg_wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign reg_we_o    = reg_we_q;
  assign reg_re_o    = reg_re_q;
  assign reg_wd_o    = reg_wd_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_error_o = rsp_error_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_prim_reg_bus_adapter.sv
// Scoreboard bench for prim_reg_bus_adapter with a small model of RC register slices.
module tb_prim_reg_bus_adapter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned NREGS = 8;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                req_i;
  logic                we_i;
  logic [AW-1:0]       addr_i;
  logic [DW-1:0]       wdata_i;
  logic [DW/8-1:0]     be_i;
  logic                gnt_o;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [DW-1:0]       rsp_rdata_o;
  logic                rsp_error_o;
  logic [NREGS-1:0]    reg_we_o;
  logic [NREGS-1:0]    reg_re_o;
  logic [DW-1:0]       reg_wd_o;
  logic [NREGS*DW-1:0] reg_q_i;

  prim_reg_bus_adapter #(
    .AW      (AW),
    .DW      (DW),
    .NumRegs (NREGS)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .gnt_o       (gnt_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_wd_o    (reg_wd_o),
    .reg_q_i     (reg_q_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  int n_strobes = 0;
  int exp_strobes = 0;

  rsp_t          exp_q[$];
  rsp_t          mon_r;
  logic [DW-1:0] exp_regs [NREGS];
  logic [DW-1:0] slice_q  [NREGS];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // RC slice model: software write loads, software read clears.
  always @(posedge clk_i) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reg_we_o[i]) slice_q[i] <= reg_wd_o;
      else if (reg_re_o[i]) slice_q[i] <= '0;
    end
  end

  always_comb begin
    reg_q_i = '0;
    for (int i = 0; i < NREGS; i++) reg_q_i[i*DW +: DW] = slice_q[i];
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
        end else begin
          mon_r = exp_q.pop_front();
          check_eq("rsp_rdata", 64'(rsp_rdata_o), 64'(mon_r.rdata));
          check_eq("rsp_error", 64'(rsp_error_o), 64'(mon_r.err));
        end
      end
      if ((reg_we_o | reg_re_o) != '0) begin
        n_strobes++;
        check_eq("strobe_onehot", 64'($countones({reg_we_o, reg_re_o})), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called one step after a rising edge with the DUT idle; returns likewise.
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [DW/8-1:0] be, input int stall);
    logic             err;
    int               idx;
    logic [NREGS-1:0] ewe, ere;
    logic [DW-1:0]    ewd, erd, held;
    rsp_t             r;
    idx = int'(addr[AW-1:2]);
    err = (idx >= NREGS) || (addr[1:0] != 2'b00) || (we && be != 4'hF);
    ewe = '0; ere = '0; ewd = '0; erd = '0;
    if (!err) begin
      if (we) begin
        ewe[idx] = 1'b1; ewd = wd; exp_regs[idx] = wd;
      end else begin
        ere[idx] = 1'b1; erd = exp_regs[idx]; exp_regs[idx] = '0;
      end
      exp_strobes++;
    end
    r.rdata = erd; r.err = err;
    exp_q.push_back(r);

    check_eq("gnt_idle", 64'(gnt_o), 64'd1);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
    rsp_ready_i = (stall == 0);
    tick();
    // Competing request while busy must be ignored.
    we_i = 1'b1; addr_i = '0; wdata_i = 32'hBAD0_BAD0; be_i = '1;
    @(negedge clk_i);
    check_eq("we_strobe", 64'(reg_we_o), 64'(ewe));
    check_eq("re_strobe", 64'(reg_re_o), 64'(ere));
    check_eq("wd", 64'(reg_wd_o), 64'(ewd));
    check_eq("gnt_access", 64'(gnt_o), 64'd0);
    check_eq("valid_access", 64'(rsp_valid_o), 64'd0);
    tick();
    @(negedge clk_i);
    check_eq("rsp_valid", 64'(rsp_valid_o), 64'd1);
    check_eq("strobe_resp", 64'({reg_we_o, reg_re_o}), 64'd0);
    held = rsp_rdata_o;
    for (int k = 0; k < stall; k++) begin
      tick();
      @(negedge clk_i);
      check_eq("valid_held", 64'(rsp_valid_o), 64'd1);
      check_eq("rdata_stable", 64'(rsp_rdata_o), 64'(held));
      check_eq("gnt_resp", 64'(gnt_o), 64'd0);
    end
    if (stall > 0) begin
      tick();
      rsp_ready_i = 1'b1;
    end
    tick();
    req_i = 1'b0;
    check_eq("idle_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("idle_gnt", 64'(gnt_o), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int nb;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    rsp_ready_i = 1'b1;
    repeat (2) tick();
    check_eq("rst_gnt", 64'(gnt_o), 64'd0);
    check_eq("rst_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("rst_strobe", 64'({reg_we_o, reg_re_o, reg_wd_o}), 64'd0);
    check_eq("rst_rsp", 64'({rsp_rdata_o, rsp_error_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check_eq("rel_gnt", 64'(gnt_o), 64'd1);

    txn(1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 0);
    txn(1'b1, 8'h08, 32'h1234_5678, 4'hF, 0);
    txn(1'b0, 8'h08, 32'h0, 4'h0, 0);       // pre-clear value, be ignored
    txn(1'b0, 8'h08, 32'h0, 4'hF, 0);       // cleared by the previous read
    txn(1'b0, 8'h20, 32'h0, 4'hF, 0);       // out of range
    txn(1'b1, 8'h00, 32'h1111_1111, 4'h3, 0); // partial write
    txn(1'b1, 8'h02, 32'h2222_2222, 4'hF, 0); // misaligned
    txn(1'b1, 8'h1C, 32'hA5A5_5A5A, 4'hF, 0);
    txn(1'b0, 8'h1C, 32'h0, 4'hF, 5);        // backpressure

    // Back-to-back writes with req and ready held high.
    for (int k = 0; k < 4; k++) exp_q.push_back('{rdata: '0, err: 1'b0});
    exp_strobes += 4;
    exp_regs[3] = 32'hCAFE_0003;
    req_i = 1'b1; we_i = 1'b1; addr_i = 8'h0C; wdata_i = 32'hCAFE_0003; be_i = 4'hF;
    rsp_ready_i = 1'b1;
    last = -1;
    nb = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (reg_we_o != '0) begin
        check_eq("b2b_vec", 64'(reg_we_o), 64'h08);
        check_eq("b2b_wd", 64'(reg_wd_o), 64'hCAFE_0003);
        if (last >= 0) check_eq("b2b_gap", 64'(c - last), 64'd3);
        last = c;
        nb++;
      end
    end
    check_eq("b2b_count", 64'(nb), 64'd4);
    tick();
    req_i = 1'b0;
    tick();
    txn(1'b0, 8'h0C, 32'h0, 4'hF, 0);

    // Reset during the access cycle.
    req_i = 1'b1; we_i = 1'b1; addr_i = 8'h10; wdata_i = 32'h5555_5555; be_i = 4'hF;
    tick();
    check_eq("pre_rst_strobe", 64'(reg_we_o), 64'h10);
    #1 rst_ni = 1'b0;
    #1;
    check_eq("rst_async_strobe", 64'({reg_we_o, reg_re_o}), 64'd0);
    check_eq("rst_async_gnt", 64'(gnt_o), 64'd0);
    req_i = 1'b0;
    tick();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check_eq("rst_rel_gnt", 64'(gnt_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_no_rsp", 64'(rsp_valid_o), 64'd0);
      tick();
    end

    txn(1'b0, 8'h04, 32'h0, 4'hF, 0);
    repeat (2) tick();
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    check_eq("strobe_total", 64'(n_strobes), 64'(exp_strobes));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/prim_reg_bus_adapter.md
Name: prim_reg_bus_adapter

Overview:
- Bus-side initiator for a bank of register slices. Converts a single-outstanding req/gnt + rsp valid/ready bus into the per-register signals the slices consume:
  - one-cycle write strobe plus write data;
  - one-cycle read strobe, used as the "we" input of RC slices;
  - read-data capture from the register q values.
- Sits between the fabric adapter and the generated register top. It is the driver end of the slice's software write/read port.

Parameters:
- AW, 8, byte-address width.
- DW, 32, data width; bus accesses are full-word only.
- NumRegs, 8, number of word-aligned registers mapped from offset 0; valid range 1..2^(AW-2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  bus request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AW  byte address
- wdata_i  in  DW  write data
- be_i  in  DW/8  byte enables
- gnt_o  out  1  request accepted this cycle
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  DW  read data (0 for writes and for errors)
- rsp_error_o  out  1  access error
- reg_we_o  out  NumRegs  one-hot write strobe, one per register
- reg_re_o  out  NumRegs  one-hot read strobe (drives RC slices)
- reg_wd_o  out  DW  write data to the slices
- reg_q_i  in  NumRegs*DW  current register values, register i at bits [i*DW +: DW]

Behaviour:
- FSM states and transitions:
  - IDLE: gnt_o = 1. On req_i, latch we_i, addr_i, wdata_i, be_i and the decoded error, then go to ACCESS. If req_i is low, stay in IDLE.
  - ACCESS: lasts exactly one cycle, then go to RESP. Actions in this cycle:
    - Non-error write: reg_we_o[idx] = 1.
    - Non-error read: reg_re_o[idx] = 1, and capture reg_q_i[idx] into the response register at the end of the cycle.
    - The captured value is the pre-strobe value, so an RC read returns the value before the clear.
  - RESP: rsp_valid_o = 1 and held stable until rsp_ready_i. On the valid && ready cycle, return to IDLE.
- gnt_o = 0 in ACCESS and RESP. A new request is never accepted in the same cycle as a response handshake.
- Latency:
  - Accept at edge N.
  - Strobe high for the cycle after N.
  - rsp_valid_o rises one cycle after the strobe cycle.
  - Minimum 3 cycles per transaction when rsp_ready_i is held at 1.
- Decode:
  - idx = addr_i[AW-1:2].
  - Error if idx >= NumRegs, or addr_i[1:0] != 0, or (we_i && be_i != all-ones).
  - An error access raises no strobe, returns rdata = 0 and error = 1.
  - Reads ignore be_i.
- reg_wd_o is the latched wdata. It is driven to 0 whenever no write strobe is active.
- Strobes:
  - reg_we_o and reg_re_o are registered outputs.
  - At most one bit is set across both vectors in any cycle.
  - Both vectors are all-zero outside ACCESS.
- Reset values: state = IDLE, gnt_o = 1 after reset release, all other outputs 0. gnt_o is 0 while rst_ni is low.
- Reset mid-transaction: the transaction is abandoned, no strobe is issued after reset asserts, and no response is produced.
- rsp_ready_i held low: RESP persists indefinitely and rsp_rdata_o / rsp_error_o are held stable.
- Inputs req_i, addr_i and the other request fields are ignored outside IDLE.

Decomposition:
- Package prim_reg_bus_pkg holds:
  - state enum {StIdle, StAccess, StResp};
  - function idx_width(NumRegs);
  - constant WordBytes = 4.
- Sub-module prim_reg_bus_decode (combinational): maps addr, we and be to a one-hot select vector and an error flag. The FSM, latches and response register live in the top.

Test Plan:
- Write 0xDEADBEEF to addr 0x04, be = 0xF, rsp_ready held at 1 -> reg_we_o = 8'b0000_0010 for exactly 1 cycle with reg_wd_o = 0xDEADBEEF; rsp_valid 2 cycles after accept with error = 0 and rdata = 0.
- Read addr 0x08 with reg_q_i[2] = 0x12345678; the bench model clears the register on reg_re_o[2] -> reg_re_o = 8'b0000_0100 for 1 cycle; rsp_rdata = 0x12345678 (pre-clear value).
- Out-of-range and partial-write errors:
  - Read addr 0x20 (NumRegs = 8) -> no strobes; rsp_error = 1, rdata = 0.
  - Write addr 0x00 with be = 0x3 -> no strobe; error = 1.
- Backpressure: read with rsp_ready = 0 for 5 cycles -> rsp_valid held with rdata stable; gnt_o = 0 and a competing req_i is ignored; return to IDLE one cycle after rsp_ready rises.
- Back-to-back writes with req_i and rsp_ready held at 1 -> one strobe every 3 cycles; strobe vectors never overlap.
- Assert rst_ni low during the ACCESS cycle -> strobes drop asynchronously; after release there is no rsp_valid, and gnt_o = 1 from the first clock.
